// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd(input bcd_digit_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder: s = (a+b+cin) mod 10, cout = (a+b+cin) >= 10.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
// Ports: a, b - BCD digits; cin - carry in; s - BCD sum digit; cout - decimal carry out.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

  // Binary total above 9 wraps by subtracting ten and produces a decimal carry.
  always_comb begin
    s    = raw[3:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      s    = 4'(raw - 5'd10);
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial DIGITS-wide BCD adder, one decimal digit per clock, LSD first.
// Latency: done in the cycle after edge k+DIGITS for a start at edge k; invalid operands report done in the cycle after edge k.
// Backpressure: start is ignored while busy; operands are latched at capture and may change during RUN.
// Ports: clk, rst (sync active-high); start, a, b, cin in; busy, done, sum, cout, invalid out.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);
  import bcd_pkg::*;

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh, b_sh;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            invalid_q;

  logic [DIGITS-1:0] nibble_ok;
  logic              ops_ok;
  logic              last_digit;
  bcd_digit_t        dig_s;
  logic              dig_cout;

  // Every nibble of both operands must be a decimal digit before any RUN cycle.
  for (genvar i = 0; i < DIGITS; i++) begin : g_check
    assign nibble_ok[i] = is_bcd(a[4*i +: 4]) && is_bcd(b[4*i +: 4]);
  end

  assign ops_ok     = &nibble_ok;
  assign last_digit = (idx_q == IDXW'(DIGITS - 1));

  // Operands shift right each RUN cycle so the current digit is always the low nibble.
  bcd_digit_adder u_digit (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = ops_ok ? RUN : DONE;
        else       state_d = IDLE;
      end
      RUN:     if (last_digit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sum_q <= '0;
            idx_q <= '0;
            if (ops_ok) begin
              a_sh      <= a;
              b_sh      <= b;
              carry_q   <= cin;
              invalid_q <= 1'b0;
            end else begin
              cout_q    <= 1'b0;
              invalid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          a_sh                 <= a_sh >> 4;
          b_sh                 <= b_sh >> 4;
          carry_q              <= dig_cout;
          sum_q[4*idx_q +: 4]  <= dig_s;
          if (last_digit) begin
            cout_q <= dig_cout;
            idx_q  <= '0;
          end else begin
            idx_q  <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench: driver pushes decimal-model expectations, monitor pops on done.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_serial_adder;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MOD = 10 ** D;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;
    int           run_cycles;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, invalid;
  logic [W-1:0] sum;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   run_cnt;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Decimal reference model
  function automatic bit has_bad_digit(input logic [W-1:0] v);
    logic [3:0] n;
    for (int i = 0; i < D; i++) begin
      n = v[4*i +: 4];
      if (n > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int to_int(input logic [W-1:0] v);
    int r = 0;
    int p = 1;
    for (int i = 0; i < D; i++) begin
      r += int'(v[4*i +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int x);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec);
    exp_t e;
    int   tot;
    if (has_bad_digit(ea) || has_bad_digit(eb)) begin
      e.sum = '0; e.cout = 1'b0; e.invalid = 1'b1; e.run_cycles = 0;
    end else begin
      tot = to_int(ea) + to_int(eb) + int'(ec);
      e.sum = to_bcd(tot % MOD); e.cout = (tot >= MOD); e.invalid = 1'b0; e.run_cycles = D;
    end
    return e;
  endfunction

  // Monitor: compares every done pulse against the oldest expectation.
  initial begin
    exp_t e;
    run_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_cnt = 0;
      end else begin
        if (busy) run_cnt++;
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending operation");
          end else begin
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e.sum));
            check("cout", 32'(cout), 32'(e.cout));
            check("invalid", 32'(invalid), 32'(e.invalid));
            check("busy_cycles", 32'(run_cnt), 32'(e.run_cycles));
          end
          run_cnt = 0;
        end
      end
    end
  end

  // Drive one start cycle; optionally record the expected result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input bit push);
    a = ia; b = ib; cin = ic; start = 1'b1;
    if (push) exp_q.push_back(model(ia, ib, ic));
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Wait (bounded) until the negedge of a cycle with done high.
  task automatic wait_done(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n > 4 * D + 10) begin
        checks++; errors++;
        $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
        break;
      end
    end
  endtask

  function automatic logic [W-1:0] rand_operand(input bit allow_bad);
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 9) == 0))
      v[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_sum", 32'(sum), 0);
    check("reset_cout", 32'(cout), 0);
    check("reset_invalid", 32'(invalid), 0);

    // Directed cases
    issue(16'h1234, 16'h5678, 1'b0, 1); wait_done("basic");
    @(negedge clk);
    issue(16'h9999, 16'h0001, 1'b0, 1); wait_done("ripple");
    issue(16'h9999, 16'h9999, 1'b1, 1); wait_done("max");
    issue(16'h0000, 16'h0000, 1'b1, 1); wait_done("cin_only");
    // Back-to-back: start asserted in the done cycle.
    issue(16'h0500, 16'h0500, 1'b0, 1); wait_done("b2b");
    @(negedge clk);
    issue(16'h12A4, 16'h0000, 1'b0, 1);
    check("invalid_latency_done", 32'(done), 1);
    wait_done("bad_a");
    @(negedge clk);
    issue(16'h0000, 16'h000F, 1'b0, 1); wait_done("bad_b");
    @(negedge clk);

    // Start while busy is ignored.
    issue(16'h1234, 16'h5678, 1'b0, 1);
    a = 16'h8888; b = 16'h8888; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("ignored_start");
    @(negedge clk);

    // Reset mid-RUN: no done, outputs cleared.
    issue(16'h1234, 16'h5678, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_sum", 32'(sum), 0);
    check("abort_cout", 32'(cout), 0);
    check("abort_invalid", 32'(invalid), 0);
    repeat (D + 2) @(negedge clk);
    issue(16'h4321, 16'h5678, 1'b1, 1); wait_done("after_abort");

    // Randomized traffic with random idle gaps and back-to-back starts.
    for (int t = 0; t < 60; t++) begin
      logic [W-1:0] ra, rb;
      ra = rand_operand(1'b1);
      rb = rand_operand(1'b1);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(ra, rb, 1'($urandom), 1);
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
